// File: rtl/nmos_clk_pkg.sv
// Shared definitions for the two-phase NMOS clock sequencer: phase states,
// default field widths and the zero-as-one length helper.
package nmos_clk_pkg;

  localparam int unsigned LEN_W_DEF = 8;
  localparam int unsigned CYC_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PH1   = 3'd1,
    GAP12 = 3'd2,
    PH2   = 3'd3,
    GAP21 = 3'd4
  } phase_e;

  // Phase widths of 0 behave as 1 so a phase is never skipped.
  function automatic int unsigned eff_len(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/nmos_phase_gen.sv
// Two-phase non-overlapping C1/C2 sequencer with programmable phase and gap
// widths, free-run, single-step, phase-start strobes and a cycle counter.
module nmos_phase_gen
  import nmos_clk_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned CYC_W = CYC_W_DEF
) (
  input  logic             main_clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [LEN_W-1:0] phi1_len,
  input  logic [LEN_W-1:0] phi2_len,
  input  logic [LEN_W-1:0] gap_len,
  output logic             C1,
  output logic             C2,
  output logic             phi1_start,
  output logic             phi2_start,
  output logic             busy,
  output logic [CYC_W-1:0] cycle_cnt
);

  phase_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] p2_q, p2_d;
  logic [LEN_W-1:0] gap_q, gap_d;
  logic             step_pend_q, step_pend_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             c1_q, c1_d, c2_q, c2_d;
  logic             s1_q, s1_d, s2_q, s2_d;
  logic             busy_q, busy_d;
  logic             start_cycle, end_cycle, enter_ph2;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p2_d        = p2_q;
    gap_d       = gap_q;
    step_pend_d = step_pend_q;
    cyc_d       = cyc_q;
    start_cycle = 1'b0;
    end_cycle   = 1'b0;
    enter_ph2   = 1'b0;

    case (state_q)
      IDLE: begin
        if (run || step) begin
          start_cycle = 1'b1;
          step_pend_d = step;
        end
      end
      PH1: begin
        if (cnt_q == '0) begin
          if (gap_q != '0) begin
            state_d = GAP12;
            cnt_d   = gap_q - LEN_W'(1);
          end else begin
            enter_ph2 = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      GAP12: begin
        if (cnt_q == '0) enter_ph2 = 1'b1;
        else             cnt_d = cnt_q - LEN_W'(1);
      end
      PH2: begin
        if (cnt_q == '0) begin
          cyc_d = cyc_q + CYC_W'(1);
          if (gap_q != '0) begin
            state_d = GAP21;
            cnt_d   = gap_q - LEN_W'(1);
          end else begin
            end_cycle = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      GAP21: begin
        if (cnt_q == '0) end_cycle = 1'b1;
        else             cnt_d = cnt_q - LEN_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // A pending single-step always ends in IDLE, even with run held high.
    if (end_cycle) begin
      if (run && !step_pend_q) begin
        start_cycle = 1'b1;
      end else begin
        state_d     = IDLE;
        step_pend_d = 1'b0;
      end
    end

    if (enter_ph2) begin
      state_d = PH2;
      cnt_d   = LEN_W'(eff_len(32'(p2_q)) - 1);
    end

    // PH1 length is consumed immediately; PH2/gap lengths are shadowed here.
    if (start_cycle) begin
      state_d = PH1;
      cnt_d   = LEN_W'(eff_len(32'(phi1_len)) - 1);
      p2_d    = phi2_len;
      gap_d   = gap_len;
    end

    c1_d   = (state_d == PH1);
    c2_d   = (state_d == PH2);
    s1_d   = (state_d == PH1) && (state_q != PH1);
    s2_d   = (state_d == PH2) && (state_q != PH2);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge main_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p2_q        <= '0;
      gap_q       <= '0;
      step_pend_q <= 1'b0;
      cyc_q       <= '0;
      c1_q        <= 1'b0;
      c2_q        <= 1'b0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p2_q        <= p2_d;
      gap_q       <= gap_d;
      step_pend_q <= step_pend_d;
      cyc_q       <= cyc_d;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      busy_q      <= busy_d;
    end
  end

  assign C1         = c1_q;
  assign C2         = c2_q;
  assign phi1_start = s1_q;
  assign phi2_start = s2_q;
  assign busy       = busy_q;
  assign cycle_cnt  = cyc_q;

endmodule

// File: tb/tb_nmos_phase_gen.sv
// Directed bench for nmos_phase_gen: hand-computed C1/C2/strobe/busy/count
// sequences for free-run, single-step, mid-cycle changes and counter wrap.
module tb_nmos_phase_gen;

  logic        main_clk = 1'b0;
  logic        rst, run, step;
  logic [7:0]  phi1_len, phi2_len, gap_len;
  logic        c1, c2, s1, s2, busy;
  logic [31:0] cnt;
  logic        n_c1, n_c2, n_s1, n_s2, n_busy;
  logic [3:0]  n_cnt;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 main_clk = ~main_clk;

  nmos_phase_gen u_dut (
    .main_clk(main_clk), .rst(rst), .run(run), .step(step),
    .phi1_len(phi1_len), .phi2_len(phi2_len), .gap_len(gap_len),
    .C1(c1), .C2(c2), .phi1_start(s1), .phi2_start(s2),
    .busy(busy), .cycle_cnt(cnt)
  );

  nmos_phase_gen #(.LEN_W(8), .CYC_W(4)) u_dut4 (
    .main_clk(main_clk), .rst(rst), .run(run), .step(step),
    .phi1_len(phi1_len), .phi2_len(phi2_len), .gap_len(gap_len),
    .C1(n_c1), .C2(n_c2), .phi1_start(n_s1), .phi2_start(n_s2),
    .busy(n_busy), .cycle_cnt(n_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge main_clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    run  = 1'b0;
    step = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0;
    phi1_len = 8'd0; phi2_len = 8'd0; gap_len = 8'd0;
    tick();
    tick();
    check("rst_c1", c1, 0);
    check("rst_c2", c2, 0);
    check("rst_strobes", {s1, s2}, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", cnt, 0);
    rst = 1'b0;

    // run=0: nothing moves
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("idle_out[%0d]", k), {c1, c2, busy}, 0);
      check($sformatf("idle_cnt[%0d]", k), cnt, 0);
    end

    // free run 2/1/3, period 7
    phi1_len = 8'd2; gap_len = 8'd1; phi2_len = 8'd3; run = 1'b1;
    for (int k = 0; k < 21; k++) begin
      int m;
      tick();
      m = k % 7;
      check($sformatf("p7_c1[%0d]", k), c1, (m < 2) ? 1 : 0);
      check($sformatf("p7_c2[%0d]", k), c2, (m >= 3 && m <= 5) ? 1 : 0);
      check($sformatf("p7_s1[%0d]", k), s1, (m == 0) ? 1 : 0);
      check($sformatf("p7_s2[%0d]", k), s2, (m == 3) ? 1 : 0);
      check($sformatf("p7_busy[%0d]", k), busy, 1);
      check($sformatf("p7_cnt[%0d]", k), cnt, (k + 1) / 7);
    end
    run = 1'b0;
    tick();
    check("p7_stop_busy", busy, 0);
    check("p7_stop_c", {c1, c2}, 0);
    check("p7_stop_cnt", cnt, 3);

    // reset asserted mid-PH2
    phi1_len = 8'd1; gap_len = 8'd0; phi2_len = 8'd3; run = 1'b1;
    tick();
    tick();
    tick();
    check("midrst_pre_c2", c2, 1);
    rst = 1'b1; run = 1'b0;
    tick();
    check("midrst_c2", c2, 0);
    check("midrst_c1", c1, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cnt", cnt, 0);
    rst = 1'b0;

    // minimum cycle 0/0/0
    phi1_len = 8'd0; gap_len = 8'd0; phi2_len = 8'd0; run = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("min_c1[%0d]", k), c1, (k % 2 == 0) ? 1 : 0);
      check($sformatf("min_c2[%0d]", k), c2, (k % 2 == 1) ? 1 : 0);
      check($sformatf("min_ovl[%0d]", k), c1 & c2, 0);
      check($sformatf("min_cnt[%0d]", k), cnt, k / 2);
    end
    run = 1'b0;
    tick();
    check("min_stop_busy", busy, 0);
    check("min_stop_cnt", cnt, 6);

    // single step 1/1/1 with a second step while busy
    phi1_len = 8'd1; gap_len = 8'd1; phi2_len = 8'd1; step = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      step = (k == 1) ? 1'b1 : 1'b0;
      check($sformatf("step_c1[%0d]", k), c1, (k == 0) ? 1 : 0);
      check($sformatf("step_c2[%0d]", k), c2, (k == 2) ? 1 : 0);
      check($sformatf("step_busy[%0d]", k), busy, (k < 4) ? 1 : 0);
      check($sformatf("step_cnt[%0d]", k), cnt, (k >= 3) ? 7 : 6);
    end

    // step and run together: step wins, run resumes after one idle clock
    run = 1'b1; step = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      step = 1'b0;
      check($sformatf("sr_busy[%0d]", k), busy, (k != 4) ? 1 : 0);
      check($sformatf("sr_c1[%0d]", k), c1, (k == 0 || k == 5) ? 1 : 0);
    end
    check("sr_cnt", cnt, 8);
    run = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("sr_end_busy", busy, 0);
    check("sr_end_cnt", cnt, 9);

    // run dropped in PH1: cycle completes unchanged
    do_reset();
    phi1_len = 8'd3; gap_len = 8'd1; phi2_len = 8'd3; run = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) run = 1'b0;
      check($sformatf("drop_c1[%0d]", k), c1, (k < 3) ? 1 : 0);
      check($sformatf("drop_c2[%0d]", k), c2, (k >= 4 && k <= 6) ? 1 : 0);
      check($sformatf("drop_busy[%0d]", k), busy, (k < 8) ? 1 : 0);
    end
    check("drop_cnt", cnt, 1);

    // phi2_len changed mid-PH1 applies from the next cycle
    run = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick();
      if (k == 0) phi2_len = 8'd5;
      check($sformatf("shd_c1[%0d]", k), c1, (k < 3 || (k >= 8 && k <= 10)) ? 1 : 0);
      check($sformatf("shd_c2[%0d]", k), c2,
            ((k >= 4 && k <= 6) || (k >= 12 && k <= 16)) ? 1 : 0);
    end
    run = 1'b0;
    tick();
    check("shd_busy", busy, 0);
    check("shd_cnt", cnt, 3);

    // 4-bit counter wrap on the narrow instance
    do_reset();
    phi1_len = 8'd0; gap_len = 8'd0; phi2_len = 8'd0; run = 1'b1;
    for (int k = 0; k < 35; k++) begin
      tick();
      check($sformatf("wrap_c1[%0d]", k), n_c1, (k % 2 == 0) ? 1 : 0);
      check($sformatf("wrap_c2[%0d]", k), n_c2, (k % 2 == 1) ? 1 : 0);
      check($sformatf("wrap_s[%0d]", k), {n_s1, n_s2}, (k % 2 == 0) ? 2 : 1);
      check($sformatf("wrap_busy[%0d]", k), n_busy, 1);
      if (k == 31) check("wrap_cnt15", n_cnt, 15);
      if (k == 32) check("wrap_cnt0", n_cnt, 0);
      if (k == 34) check("wrap_cnt1", n_cnt, 1);
      if (k == 34) check("wrap_wide17", cnt, 17);
    end
    run = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nmos_phase_gen.md
Name: nmos_phase_gen

Overview:
- Two-phase non-overlapping clock sequencer that drives the C1 (PHI1) and C2 (PHI2) enables of the NMOS register primitives from the single simulation clock.
- Provides programmable phase and gap widths, free-run, stop at cycle boundary, single-step, phase-start strobes and a completed-cycle counter.
- Sits beside the clock generator; its C1/C2 fan out to every two-phase latch and flip-flop in the NMOS netlist.

Parameters:
- LEN_W, 8, width of phase/gap length fields.
- CYC_W, 32, width of completed-cycle counter.

Ports:
- main_clk  in  1  simulation clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = free-run cycles.
- step  in  1  pulse; request exactly one full cycle when idle.
- phi1_len  in  LEN_W  PHI1 high width in main_clk cycles (0 treated as 1).
- phi2_len  in  LEN_W  PHI2 high width (0 treated as 1).
- gap_len  in  LEN_W  dead time between phases (0 = no gap).
- C1  out  1  PHI1 enable, registered.
- C2  out  1  PHI2 enable, registered.
- phi1_start  out  1  one-cycle strobe, high in first cycle C1=1.
- phi2_start  out  1  one-cycle strobe, high in first cycle C2=1.
- busy  out  1  1 whenever state != IDLE.
- cycle_cnt  out  CYC_W  number of completed PHI2 phases, wraps modulo 2^CYC_W.

Behaviour:
- Interface: one clock main_clk; rst is synchronous and active-high. rst=1 at any edge, including mid-cycle, forces state IDLE, C1=C2=0, both strobes 0, busy=0, cycle_cnt=0 and clears step_pend.
- FSM states: IDLE, PH1, GAP12, PH2, GAP21. Outputs are registered from next-state: C1=1 iff state=PH1, C2=1 iff state=PH2. C1&C2 is never 1.
- IDLE -> PH1 at an edge where run=1 or step=1. A step accepted here sets step_pend.
- On entry to PH1, latch phi1_len, phi2_len and gap_len into shadow registers. Input changes mid-cycle take effect at the next PH1 entry.
- PH1 lasts max(phi1_len,1) clocks, then goes to GAP12, or to PH2 directly if gap=0.
- GAP12 lasts gap clocks -> PH2.
- PH2 lasts max(phi2_len,1) clocks. On exit, cycle_cnt increments (wrapping), then go to GAP21, or to the end-of-cycle decision if gap=0.
- GAP21 lasts gap clocks, then the end-of-cycle decision is made.
- End-of-cycle decision, sampled at that edge:
  - run=1 and step_pend=0: -> PH1 (back-to-back, no idle cycle).
  - otherwise: -> IDLE and clear step_pend.
- run deasserted mid-cycle: the cycle always completes; phases are never truncated.
- step while busy: ignored, not queued.
- step and run both 1 in IDLE: single-step wins for that cycle; the run level is re-evaluated at the next end-of-cycle.
- Minimum cycle is 2 clocks (lengths 0/0/0), giving C1,C2,C1,C2...
- Period = max(p1,1) + max(p2,1) + 2*gap.
- A single down-counter (LEN_W bits) is reloaded on each state entry with (len-1), and the state exits when it reaches 0.

Decomposition:
- Shared package nmos_clk_pkg holds:
  - the state enum (IDLE, PH1, GAP12, PH2, GAP21);
  - LEN_W/CYC_W defaults;
  - the function eff_len(len) = (len==0) ? 1 : len.
- No sub-module needed. The duration down-counter stays inline; optional factoring is nmos_dur_cnt, but it is not required.

Test Plan:
- Reset, then run=0 for 10 clocks -> C1=C2=0, busy=0, cycle_cnt=0; rst asserted mid-PH2 -> next cycle C2=0, cnt=0.
- run=1, phi1=2, gap=1, phi2=3 -> repeating C1 1,1,0,0,0,0,0 / C2 0,0,0,1,1,1,0 (period 7); phi1_start/phi2_start one clock each; cycle_cnt +1 per period.
- gap=0, phi1=0, phi2=0, run=1 -> C1/C2 alternate every clock, never both high; cycle_cnt increments every 2 clocks.
- step pulse in IDLE with lengths 1/1/1 -> exactly one C1 pulse then one C2 pulse, busy high 4 clocks, cycle_cnt=1. A second step pulse issued while busy produces nothing.
- run dropped during PH1 (phi1=3, gap=1, phi2=3) -> remaining PH1, GAP12, full PH2 and GAP21 complete, then IDLE. phi2_len changed mid-PH1 from 3 to 5 -> current PH2 still 3 clocks, next cycle's PH2 is 5.
- CYC_W=4, run 17 cycles -> cycle_cnt reaches 15 then wraps to 0 then 1.
